// File: rtl/dmux8_byte_assembler.sv
// Rebuilds bytes from the eight registered demux output lines, checks select ordering,
// and presents each completed byte on a valid/ready port with sticky error flags.
module dmux8_byte_assembler #(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       a,
   input  logic       b,
   input  logic       c,
   input  logic       d,
   input  logic       e,
   input  logic       f,
   input  logic       g,
   input  logic       h,
   input  logic [2:0] sel,
   input  logic       bit_valid,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic       overrun,
   output logic       seq_err,
   output logic [7:0] byte_count
);

   logic [2:0] sel_d;
   logic       bv_d;
   logic [7:0] shift;
   logic [2:0] idx;
   logic [7:0] hold;

   logic [7:0] lines;
   logic       data_bit;
   logic [2:0] pos;
   logic [7:0] completed;
   logic [7:0] restart_byte;
   logic       in_order;
   logic       accept;

   // Demux lines reflect last cycle's select, so decode with the delayed copy.
   always_comb begin
      lines        = {h, g, f, e, d, c, b, a};
      data_bit     = lines[sel_d];
      pos          = LSB_FIRST ? sel_d : (3'd7 - sel_d);
      completed    = shift;
      completed[pos] = data_bit;
      restart_byte = 8'h00;
      restart_byte[pos] = data_bit;
      in_order     = bv_d && (sel_d == idx);
      accept       = byte_valid && byte_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_d      <= 3'd0;
         bv_d       <= 1'b0;
         shift      <= 8'h00;
         idx        <= 3'd0;
         hold       <= 8'h00;
         byte_valid <= 1'b0;
         overrun    <= 1'b0;
         seq_err    <= 1'b0;
         byte_count <= 8'h00;
      end else begin
         sel_d <= sel;
         bv_d  <= bit_valid;

         if (accept) begin
            byte_count <= byte_count + 8'd1;
            byte_valid <= 1'b0;
         end

         if (in_order) begin
            shift <= completed;
            idx   <= idx + 3'd1;
            // A completion on the accept cycle refills the holding register seamlessly.
            if (idx == 3'd7) begin
               if (!byte_valid || accept) begin
                  hold       <= completed;
                  byte_valid <= 1'b1;
               end else begin
                  overrun <= 1'b1;
               end
            end
         end else if (bv_d) begin
            seq_err <= 1'b1;
            if (sel_d == 3'd0) begin
               shift <= restart_byte;
               idx   <= 3'd1;
            end else begin
               shift <= 8'h00;
               idx   <= 3'd0;
            end
         end
      end
   end

   assign byte_out = hold;

endmodule

// File: tb/tb_dmux8_byte_assembler.sv
// Scoreboard bench for dmux8_byte_assembler: a registered demux model feeds an LSB-first
// and an MSB-first instance; bytes expected on the LSB-first port are queued and popped on accept.
module tb_dmux8_byte_assembler;

   logic       clk;
   logic       rst;
   logic [2:0] sel;
   logic       din;
   logic       bit_valid;
   logic       byte_ready;
   logic [7:0] lines;

   logic [7:0] lsb_byte_out;
   logic       lsb_byte_valid;
   logic       lsb_overrun;
   logic       lsb_seq_err;
   logic [7:0] lsb_byte_count;

   logic [7:0] msb_byte_out;
   logic       msb_byte_valid;
   logic       msb_overrun;
   logic       msb_seq_err;
   logic [7:0] msb_byte_count;

   logic [7:0] exp_q[$];
   int         checks;
   int         failures;

   dmux8_byte_assembler dut_lsb (
      .clk(clk), .rst(rst),
      .a(lines[0]), .b(lines[1]), .c(lines[2]), .d(lines[3]),
      .e(lines[4]), .f(lines[5]), .g(lines[6]), .h(lines[7]),
      .sel(sel), .bit_valid(bit_valid),
      .byte_out(lsb_byte_out), .byte_valid(lsb_byte_valid), .byte_ready(byte_ready),
      .overrun(lsb_overrun), .seq_err(lsb_seq_err), .byte_count(lsb_byte_count)
   );

   dmux8_byte_assembler #(.LSB_FIRST(1'b0)) dut_msb (
      .clk(clk), .rst(rst),
      .a(lines[0]), .b(lines[1]), .c(lines[2]), .d(lines[3]),
      .e(lines[4]), .f(lines[5]), .g(lines[6]), .h(lines[7]),
      .sel(sel), .bit_valid(bit_valid),
      .byte_out(msb_byte_out), .byte_valid(msb_byte_valid), .byte_ready(byte_ready),
      .overrun(msb_overrun), .seq_err(msb_seq_err), .byte_count(msb_byte_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered 1-to-8 demux: the selected line carries the input bit, the rest are low.
   always_ff @(posedge clk) begin
      lines <= 8'(din) << sel;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic logic [7:0] reverseByte(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   task automatic applyStimulus(input logic [2:0] s, input logic dv, input logic v);
      sel       = s;
      din       = dv;
      bit_valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(3'd0, 1'b0, 1'b0);
   endtask

   task automatic sendByte(input logic [7:0] value, input bit push);
      if (push) exp_q.push_back(value);
      for (int k = 0; k < 8; k++) applyStimulus(3'(k), value[k], 1'b1);
   endtask

   task automatic doReset();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      exp_q.delete();
   endtask

   // Every accepted byte on the LSB-first port must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && lsb_byte_valid && byte_ready) begin
         if (exp_q.size() == 0)
            checkOutput("sb_underflow", 32'(exp_q.size()), 32'd1);
         else
            checkOutput("sb_byte", 32'(lsb_byte_out), 32'(exp_q.pop_front()));
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      checks     = 0;
      failures   = 0;
      rst        = 1'b1;
      sel        = 3'd0;
      din        = 1'b0;
      bit_valid  = 1'b0;
      byte_ready = 1'b0;
      @(posedge clk);
      #1;
      doReset();

      $display("[TB] reset state");
      checkOutput("rst_byte_valid", 32'(lsb_byte_valid), 32'd0);
      checkOutput("rst_byte_out", 32'(lsb_byte_out), 32'h00);
      checkOutput("rst_overrun", 32'(lsb_overrun), 32'd0);
      checkOutput("rst_seq_err", 32'(lsb_seq_err), 32'd0);
      checkOutput("rst_byte_count", 32'(lsb_byte_count), 32'd0);

      $display("[TB] in-order byte");
      byte_ready = 1'b1;
      sendByte(8'hA5, 1'b1);
      idle(1);
      checkOutput("io_valid_hi", 32'(lsb_byte_valid), 32'd1);
      checkOutput("io_byte_out", 32'(lsb_byte_out), 32'hA5);
      idle(1);
      checkOutput("io_valid_lo", 32'(lsb_byte_valid), 32'd0);
      checkOutput("io_count", 32'(lsb_byte_count), 32'd1);
      checkOutput("io_overrun", 32'(lsb_overrun), 32'd0);
      checkOutput("io_seq_err", 32'(lsb_seq_err), 32'd0);

      $display("[TB] msb-first mapping");
      doReset();
      byte_ready = 1'b1;
      sendByte(8'hA5, 1'b1);
      idle(1);
      checkOutput("msb_valid", 32'(msb_byte_valid), 32'd1);
      checkOutput("msb_a5", 32'(msb_byte_out), 32'(reverseByte(8'hA5)));
      sendByte(8'h01, 1'b1);
      idle(1);
      checkOutput("msb_01", 32'(msb_byte_out), 32'(reverseByte(8'h01)));
      checkOutput("lsb_01", 32'(lsb_byte_out), 32'h01);
      idle(1);

      $display("[TB] back-to-back with stalled consumer");
      doReset();
      byte_ready = 1'b0;
      sendByte(8'h3C, 1'b1);
      sendByte(8'hC3, 1'b0);
      idle(2);
      checkOutput("stall_valid", 32'(lsb_byte_valid), 32'd1);
      checkOutput("stall_hold", 32'(lsb_byte_out), 32'h3C);
      checkOutput("stall_overrun", 32'(lsb_overrun), 32'd1);
      byte_ready = 1'b1;
      idle(1);
      byte_ready = 1'b0;
      checkOutput("stall_count", 32'(lsb_byte_count), 32'd1);
      checkOutput("stall_drained", 32'(lsb_byte_valid), 32'd0);

      $display("[TB] same-cycle accept and completion");
      doReset();
      byte_ready = 1'b0;
      sendByte(8'h11, 1'b1);
      sendByte(8'h22, 1'b1);
      byte_ready = 1'b1;
      idle(1);
      byte_ready = 1'b0;
      checkOutput("same_valid", 32'(lsb_byte_valid), 32'd1);
      checkOutput("same_byte", 32'(lsb_byte_out), 32'h22);
      checkOutput("same_overrun", 32'(lsb_overrun), 32'd0);
      checkOutput("same_count", 32'(lsb_byte_count), 32'd1);
      byte_ready = 1'b1;
      idle(1);
      checkOutput("same_count2", 32'(lsb_byte_count), 32'd2);

      $display("[TB] sequence error");
      doReset();
      byte_ready = 1'b1;
      for (int k = 0; k < 3; k++) applyStimulus(3'(k), 1'b0, 1'b1);
      sendByte(8'hFF, 1'b1);
      idle(1);
      checkOutput("seq_err_flag", 32'(lsb_seq_err), 32'd1);
      checkOutput("seq_byte", 32'(lsb_byte_out), 32'hFF);
      checkOutput("seq_overrun", 32'(lsb_overrun), 32'd0);
      idle(1);

      $display("[TB] reset mid-byte");
      for (int k = 0; k < 5; k++) applyStimulus(3'(k), 1'b1, 1'b1);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      exp_q.delete();
      checkOutput("mid_rst_seq_err", 32'(lsb_seq_err), 32'd0);
      checkOutput("mid_rst_valid", 32'(lsb_byte_valid), 32'd0);
      sendByte(8'h5A, 1'b1);
      idle(1);
      checkOutput("mid_byte", 32'(lsb_byte_out), 32'h5A);
      checkOutput("mid_seq_err", 32'(lsb_seq_err), 32'd0);
      idle(1);
      checkOutput("mid_count", 32'(lsb_byte_count), 32'd1);

      $display("[TB] byte_count wrap");
      doReset();
      byte_ready = 1'b1;
      for (int n = 0; n < 255; n++) sendByte(8'($urandom), 1'b1);
      idle(2);
      checkOutput("count_255", 32'(lsb_byte_count), 32'd255);
      sendByte(8'($urandom), 1'b1);
      idle(2);
      checkOutput("count_wrap", 32'(lsb_byte_count), 32'd0);
      checkOutput("wrap_overrun", 32'(lsb_overrun), 32'd0);
      checkOutput("wrap_seq_err", 32'(lsb_seq_err), 32'd0);
      checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmux8_byte_assembler.md
# dmux8_byte_assembler

Downstream collector for the 8-way registered demultiplexer. It watches the eight demux output lines `a`..`h` and rebuilds one byte from eight consecutive serial bits steered through sel 0..7. It checks that the select sequence is in order and presents each completed byte on a valid/ready output port with overrun and sequence-error reporting. It sits between the demux stage and any byte-wide consumer.

## Interface

- `LSB_FIRST`, default 1: 1 = select index k writes byte bit k; 0 = select index k writes byte bit 7-k.
- `clk`  input  1  rising-edge clock, shared with the demux stage.
- `rst`  input  1  synchronous, active-high reset, sampled on rising `clk`.
- `a`,`b`,`c`,`d`,`e`,`f`,`g`,`h`  input  1 each  demux outputs for select 0..7. The demux registers these on the clock edge.
- `sel`  input  3  the same select value driven into the demux, unregistered.
- `bit_valid`  input  1  asserted with `sel`/`in` when the demux input carries a real data bit.
- `byte_out`  output  8  assembled byte. Stable while `byte_valid` is high.
- `byte_valid`  output  1  holding register contains a byte.
- `byte_ready`  input  1  consumer accepts the byte when `byte_valid && byte_ready` at a rising edge.
- `overrun`  output  1  sticky: a completed byte was dropped because the holding register was full.
- `seq_err`  output  1  sticky: select index arrived out of order.
- `byte_count`  output  8  number of bytes accepted by the consumer. Wraps 255 -> 0.

## Operation

- **Alignment.** The demux output reflects the `sel`/`in` presented one edge earlier. The block therefore registers `sel` -> `sel_d` and `bit_valid` -> `bv_d` every cycle. All assembly logic uses `sel_d`, `bv_d` and the current `a`..`h`.
- **Bit extraction.** The data bit is the line indexed by `sel_d`: `a` for 0 through `h` for 7. Non-selected lines are ignored.
- **Internal state:**
  - `shift` (8 bits): partial byte.
  - `idx` (3 bits): next expected select.
  - `hold` (8 bits) and `byte_valid`: output holding register.
- **Bit with `bv_d`=1 and `sel_d`==`idx`:**
  - Write the bit into `shift` at position `sel_d` (or 7-`sel_d` when `LSB_FIRST`=0).
  - Then `idx` <= `idx`+1, wrapping 7 -> 0.
- **Completion.** When a bit is written with `idx`==7, the byte is complete: it is `shift` including the bit written this cycle.
  - If `byte_valid`=0, or the byte is being accepted this same cycle, then `hold` <= completed byte and `byte_valid` <= 1.
  - Otherwise the completed byte is discarded, `overrun` <= 1, and `hold` is unchanged.
- **Out-of-order bit** (`bv_d`=1 and `sel_d`!=`idx`):
  - `seq_err` <= 1 and the partial byte is abandoned.
  - If `sel_d`==0: the bit is written as bit 0 of a new byte and `idx` <= 1.
  - Else: the bit is dropped and `idx` <= 0.
- **Idle cycle.** With `bv_d`=0, no state changes except the output handshake.
- **Handshake:**
  - Accept on `byte_valid && byte_ready`: `byte_count` increments.
  - `byte_valid` falls next cycle unless a new byte completes in the same cycle, in which case it stays high with the new byte.
  - `byte_out` = `hold` at all times.
- **Sticky flags.** `overrun` and `seq_err` clear only on `rst`.

## Timing

- **Reset** (synchronous, dominant over all other activity), all values zero after reset:
  - `sel_d`=0, `bv_d`=0, `shift`=0x00, `idx`=0, `hold`=0x00.
  - Outputs: `byte_valid`=0, `byte_out`=0x00, `overrun`=0, `seq_err`=0, `byte_count`=0.
- **Latency.** `sel=7`/`bit_valid` presented before edge N -> demux output after N -> assembler samples at N+1 -> `byte_valid` high after edge N+1.
- **Throughput.** One byte per 8 cycles sustained, with no bubble required between bytes.
- **Mid-byte reset** discards the partial byte and any held byte. Assembly restarts at `idx`=0.
- **Simultaneous accept and completion.** The new byte is loaded and there is no overrun.
- **Consumer stalled across two completions.** First byte held, second dropped, `overrun`=1.
- **`byte_count`** wraps from 255 to 0 with no flag.

## Test plan

- **In-order byte.** Reset, then drive `bit_valid`=1 with sel 0..7 and in bits of 0xA5 (LSB first), `byte_ready`=1 → `byte_valid` pulses 1 cycle with `byte_out`=0xA5, `byte_count`=1, both flags 0.
- **MSB-first mapping.** With `LSB_FIRST`=0, send the same stream → `byte_out`=0xA5 bit-reversed = 0xA5 (palindrome check). Then repeat with 0x01 → `byte_out`=0x80.
- **Back-to-back and stall.** Send 0x3C then 0xC3 with `byte_ready`=0 → `byte_valid`=1 holding 0x3C, `overrun`=1. Raise `byte_ready` → 0x3C accepted, `byte_count`=1.
- **Same-cycle accept.** Send 0x11 then 0x22 continuously, asserting `byte_ready` only in the cycle 0x22 completes → 0x11 accepted, 0x22 loaded, `byte_valid` stays 1, `overrun`=0.
- **Sequence error.** Send sel 0,1,2, then sel 0 restarting 0xFF → `seq_err`=1, next `byte_out`=0xFF.
- **Reset mid-byte.** After sel 0..4, assert `rst` for 1 cycle, then send a full 0x5A → `byte_out`=0x5A with `seq_err`=0.
